// File: rtl/oht_multi_if.sv
// Signal bundle for the multi-channel online health test.
// The master drives raw samples and debug controls; the slave returns codes and status.
interface oht_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CAL_W  = 6
);
    logic [NUM_CH-1:0]       adc_in;
    logic                    sample_en;
    logic                    debug_mode;
    logic [2*CAL_W-1:0]      debug_cal;
    logic [NUM_CH*CAL_W-1:0] calibration_arr_n;
    logic [NUM_CH*CAL_W-1:0] calibration_arr_p;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_perm_fail;
    logic [NUM_CH-1:0]       bit_out;
    logic [NUM_CH-1:0]       bit_out_valid;
    logic                    any_valid;
    logic                    all_fail;

    modport master (
        output adc_in, sample_en, debug_mode, debug_cal,
        input  calibration_arr_n, calibration_arr_p, ch_valid,
        input  ch_perm_fail, bit_out, bit_out_valid, any_valid, all_fail
    );

    modport slave (
        input  adc_in, sample_en, debug_mode, debug_cal,
        output calibration_arr_n, calibration_arr_p, ch_valid,
        output ch_perm_fail, bit_out, bit_out_valid, any_valid, all_fail
    );
endinterface

// File: rtl/oht_multi.sv
// Multi-channel online health test for raw entropy sources.
// Repetition and proportion tests per channel steer the ADC calibration codes.
module oht_multi #(
    parameter int NUM_CH        = 4,
    parameter int WIN_LEN       = 1024,
    parameter int RCT_CUTOFF    = 32,
    parameter int APT_LO        = 461,
    parameter int APT_HI        = 563,
    parameter int CAL_W         = 6,
    parameter int CAL_RETRY_MAX = 8,
    parameter int FAIL_MAX      = 3
) (
    input logic        clk,
    input logic        rst,
    oht_multi_if.slave bus
);
    localparam int WW = $clog2(WIN_LEN);
    localparam int OW = WW + 1;
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int TW = $clog2(CAL_RETRY_MAX + 1);
    localparam int FW = $clog2(FAIL_MAX + 1);

    localparam logic [CAL_W-1:0] CMAX  = '1;
    localparam logic [WW-1:0]    WLAST = WW'(WIN_LEN - 1);
    localparam logic [OW-1:0]    WFULL = OW'(WIN_LEN);
    localparam logic [OW-1:0]    W8    = OW'(WIN_LEN / 8);
    localparam logic [OW-1:0]    W4    = OW'(WIN_LEN / 4);
    localparam logic [OW-1:0]    ALO   = OW'(APT_LO);
    localparam logic [OW-1:0]    AHI   = OW'(APT_HI);
    localparam logic [RW-1:0]    RCUT  = RW'(RCT_CUTOFF);
    localparam logic [TW-1:0]    TMAX  = TW'(CAL_RETRY_MAX);
    localparam logic [FW-1:0]    FMAX  = FW'(FAIL_MAX);

    typedef enum logic [1:0] {CALIB, MONITOR, FAIL} state_t;

    // Arithmetic in CAL_W+1 bits so a carry or borrow clamps instead of wrapping.
    function automatic logic [CAL_W-1:0] sat_add(input logic [CAL_W-1:0] c,
                                                 input logic [1:0] s);
        logic [CAL_W:0] t;
        t = {1'b0, c} + {{(CAL_W-1){1'b0}}, s};
        return t[CAL_W] ? CMAX : t[CAL_W-1:0];
    endfunction

    function automatic logic [CAL_W-1:0] sat_sub(input logic [CAL_W-1:0] c,
                                                 input logic [1:0] s);
        logic [CAL_W:0] t;
        t = {1'b0, c} - {{(CAL_W-1){1'b0}}, s};
        return t[CAL_W] ? '0 : t[CAL_W-1:0];
    endfunction

    logic [CAL_W-1:0]  w_dn;
    logic [CAL_W-1:0]  w_dp;
    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_pfail;

    assign w_dn = bus.debug_cal[2*CAL_W-1:CAL_W];
    assign w_dp = bus.debug_cal[CAL_W-1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        logic             r_last;
        logic [RW-1:0]    r_run;
        logic [WW-1:0]    r_win;
        logic [OW-1:0]    r_ones;
        logic [TW-1:0]    r_retry;
        logic [FW-1:0]    r_fail;
        logic [CAL_W-1:0] r_n;
        logic [CAL_W-1:0] r_p;
        logic             r_valid;
        logic             r_pfail;
        logic             r_bo;
        logic             r_bov;

        logic          w_s;
        logic          w_same;
        logic [RW-1:0] w_run;
        logic          w_rct;
        logic          w_end;
        logic [OW-1:0] w_ones;
        logic [OW-1:0] w_k;
        logic          w_low;
        logic          w_pass;
        logic [1:0]    w_step;
        logic [TW-1:0] w_retry;
        logic [FW-1:0] w_fail;

        assign w_s     = bus.adc_in[g];
        // A run that just hit the cutoff starts over at the following sample.
        assign w_same  = (r_run != '0) && (r_run != RCUT) && (w_s == r_last);
        assign w_run   = w_same ? r_run + 1'b1 : RW'(1);
        assign w_rct   = (w_run == RCUT);
        assign w_end   = (r_win == WLAST);
        assign w_ones  = r_ones + {{(OW-1){1'b0}}, w_s};
        assign w_low   = (w_ones < ALO);
        assign w_pass  = !w_low && (w_ones <= AHI);
        assign w_k     = w_low ? w_ones : WFULL - w_ones;
        assign w_step  = (w_k < W8) ? 2'd3 : (w_k < W4) ? 2'd2 : 2'd1;
        assign w_retry = r_retry + 1'b1;
        assign w_fail  = r_fail + 1'b1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= CALIB;
                r_last  <= 1'b0;
                r_run   <= '0;
                r_win   <= '0;
                r_ones  <= '0;
                r_retry <= '0;
                r_fail  <= '0;
                r_n     <= '0;
                r_p     <= '0;
                r_valid <= 1'b0;
                r_pfail <= 1'b0;
                r_bo    <= 1'b0;
                r_bov   <= 1'b0;
            end else begin
                r_bo  <= w_s;
                r_bov <= bus.sample_en & r_valid;
                if (bus.sample_en) begin
                    r_last <= w_s;
                    r_run  <= w_run;
                    if (w_rct || w_end) begin
                        r_win  <= '0;
                        r_ones <= '0;
                    end else begin
                        r_win  <= r_win + 1'b1;
                        r_ones <= w_ones;
                    end
                    unique case (r_state)
                        CALIB: begin
                            if (w_rct || (w_end && !w_pass)) begin
                                if (w_rct) begin
                                    if (w_s) r_n <= sat_add(r_n, 2'd3);
                                    else     r_p <= sat_add(r_p, 2'd3);
                                end else if (w_low) begin
                                    if (r_p == CMAX) r_n <= sat_sub(r_n, w_step);
                                    else             r_p <= sat_add(r_p, w_step);
                                end else begin
                                    if (r_n == CMAX) r_p <= sat_sub(r_p, w_step);
                                    else             r_n <= sat_add(r_n, w_step);
                                end
                                r_retry <= w_retry;
                                if (w_retry >= TMAX) begin
                                    r_state <= FAIL;
                                    r_pfail <= 1'b1;
                                end
                            end else if (w_end) begin
                                r_state <= MONITOR;
                                r_valid <= 1'b1;
                                r_retry <= '0;
                            end
                        end
                        MONITOR: begin
                            if (w_rct || (w_end && !w_pass)) begin
                                r_valid <= 1'b0;
                                r_fail  <= w_fail;
                                if (w_fail >= FMAX) begin
                                    r_state <= FAIL;
                                    r_pfail <= 1'b1;
                                end else begin
                                    r_state <= CALIB;
                                end
                            end else if (w_end) begin
                                r_fail <= '0;
                            end
                        end
                        FAIL: begin
                            r_valid <= 1'b0;
                        end
                        default: r_state <= FAIL;
                    endcase
                end
                // Debug codes win over any automatic step taken above.
                if (bus.debug_mode) begin
                    r_n <= w_dn;
                    r_p <= w_dp;
                end
            end
        end

        assign bus.calibration_arr_n[g*CAL_W +: CAL_W] = r_n;
        assign bus.calibration_arr_p[g*CAL_W +: CAL_W] = r_p;
        assign bus.bit_out[g]       = r_bo;
        assign bus.bit_out_valid[g] = r_bov;
        assign w_valid[g]           = r_valid;
        assign w_pfail[g]           = r_pfail;
    end

    assign bus.ch_valid     = w_valid;
    assign bus.ch_perm_fail = w_pfail;
    assign bus.any_valid    = |w_valid;
    assign bus.all_fail     = &w_pfail;
endmodule

// File: doc/oht_multi.md
OHT_MULTI -- requirements
Module: oht_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent entropy channels.
REQ-002 SHALL have parameter WIN_LEN, default 1024, samples per proportion window (power of two, >=64).
REQ-003 SHALL have parameter RCT_CUTOFF, default 32, repetition-run length that raises a repetition event.
REQ-004 SHALL have parameters APT_LO/APT_HI, default 461/563, inclusive pass band for ones per window.
REQ-005 SHALL have parameter CAL_W, default 6, calibration code width per polarity.
REQ-006 SHALL have parameters CAL_RETRY_MAX/FAIL_MAX, default 8/3, window retry limit in calibration and monitor-failure limit.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port adc_in, input, NUM_CH, one raw entropy bit per channel.
REQ-010 SHALL have port sample_en, input, 1, adc_in is a new sample this cycle; all counters and state frozen when 0.
REQ-011 SHALL have port debug_mode, input, 1, forces calibration codes from debug_cal.
REQ-012 SHALL have port debug_cal, input, 2*CAL_W, {n_code, p_code} applied to all channels.
REQ-013 SHALL have ports calibration_arr_n/calibration_arr_p, output, NUM_CH*CAL_W, per-channel codes; channel i at [i*CAL_W +: CAL_W].
REQ-014 SHALL have ports ch_valid/ch_perm_fail, output, NUM_CH, per-channel healthy and sticky-failure flags.
REQ-015 SHALL have ports bit_out/bit_out_valid, output, NUM_CH, registered conditioned-ready bits and per-channel qualifiers.
REQ-016 SHALL have ports any_valid/all_fail, output, 1, OR of ch_valid and AND of ch_perm_fail.

Function
REQ-017 SHALL run per channel an FSM CALIB -> MONITOR -> FAIL, with fully independent counters, codes and states.
REQ-018 SHALL keep run_cnt of consecutive identical samples (first sample counts 1); a run reaching RCT_CUTOFF raises rct_event and restarts run_cnt at 1 on the next sample.
REQ-019 SHALL count win_cnt 0..WIN_LEN-1 and ones_cnt of samples including the last; at win_cnt==WIN_LEN-1 the window ends and both clear for the next sample.
REQ-020 SHALL, in CALIB at window end with ones in [APT_LO,APT_HI], go to MONITOR and set ch_valid next cycle.
REQ-021 SHALL, in CALIB at a failing window end, step codes: ones<WIN_LEN/8 step 3, <WIN_LEN/4 step 2, else step 1; low ones raises p (if p saturated, lowers n); high ones mirrored (WIN_LEN-ones thresholds) raises n (if n saturated, lowers p).
REQ-022 SHALL saturate codes at 0 and 2^CAL_W-1, computing in CAL_W+1 bits with no wrap.
REQ-023 SHALL, on rct_event in CALIB, step by 3 (run of 1s: n+3, run of 0s: p+3, saturating) and restart the window.
REQ-024 SHALL count failing CALIB windows and rct_events in retry_cnt; reaching CAL_RETRY_MAX goes to FAIL; retry_cnt clears on entry to MONITOR.
REQ-025 SHALL, in MONITOR, on rct_event or failing window: clear ch_valid next cycle, increment fail_cnt, restart window, return to CALIB; a passing window clears fail_cnt.
REQ-026 SHALL enter FAIL when fail_cnt reaches FAIL_MAX; FAIL is sticky until rst, ch_perm_fail=1, ch_valid=0.
REQ-027 SHALL give rct_event priority over a same-cycle window end; that window is discarded, not evaluated.
REQ-028 SHALL, while debug_mode=1, load debug_cal into all codes every cycle and suppress automatic steps; FSM, counters and FAIL transitions continue.
REQ-029 SHALL register bit_out[i]=adc_in[i] and bit_out_valid[i]=sample_en & ch_valid[i] with 1-cycle latency.

Reset
REQ-030 SHALL on rst clear all counters, codes to 0, states to CALIB, and all outputs to 0, overriding any mid-window or FAIL condition.

Verification
REQ-031 Alternating 0/1 on ch0, sample_en=1 -> ch_valid[0]=1 one cycle after sample 1024; codes stay 0.
REQ-032 ch1 constant 1 -> rct_event at sample 32, n code 3, then 6, 9 ...; FAIL after 8 retries, ch_perm_fail[1]=1.
REQ-033 ch2 with 100 ones per window -> p steps +3 per window; at p=63 n decrements; saturation holds 63/0.
REQ-034 ch3 valid, then 3 windows of 700 ones -> valid drops after each; with no passing window between, ch_perm_fail[3]=1.
REQ-035 debug_mode=1, debug_cal=0x9C5 -> all n=0x27, p=0x05, unchanged by failing windows; rst mid-window -> all outputs 0 next cycle.
REQ-036 sample_en toggled 50% with alternating data -> valid after 1024 accepted samples, not cycles.
